multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_shift_mul.sv | 94 +++++++++
 rtl/multicycle_alu.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_alu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle ALU: opcode constants, the control
// FSM state encoding and the mode selector of the iterative datapath.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        MUL   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DP_SLL = 2'b00,
        DP_SRL = 2'b01,
        DP_MUL = 2'b10
    } dp_mode_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_mul.sv
// ----------------------------------------------------------------------------
// alu_shift_mul
// Iterative datapath: shifts one bit per cycle (SLL/SRL) or performs one
// shift-add multiplier step per cycle (MUL, only when MULTICYCLE_ALU_MUL_EN
// is defined). Runs on its own once loaded, until its counter reaches zero.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load            start a new operation (mode, a, b, k sampled)
//   mode            DP_SLL / DP_SRL / DP_MUL
//   a, b            operand A, operand B (multiplier)
//   k               shift count (must be non-zero for shifts)
//   last            current cycle performs the final step
//   lo_nxt, hi_nxt  value of the result words after the current step
// ----------------------------------------------------------------------------
module alu_shift_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  dp_mode_e         mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   k,
    output logic             last,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    // The counter must be able to hold WIDTH for a full multiply.
    localparam int CW = SHW + 1;

    dp_mode_e         mode_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] lo_r;
`ifdef MULTICYCLE_ALU_MUL_EN
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH:0]   sum_s;
`endif

    assign last = (cnt_r == CW'(1));

    // One step of the selected operation, computed from the current registers.
    always_comb begin
        lo_nxt = lo_r;
        hi_nxt = {WIDTH{1'b0}};
`ifdef MULTICYCLE_ALU_MUL_EN
        sum_s  = {1'b0, hi_r} + {1'b0, (lo_r[0] ? mcand_r : {WIDTH{1'b0}})};
`endif
        case (mode_r)
            DP_SLL: lo_nxt = lo_r << 1'b1;
            DP_SRL: lo_nxt = lo_r >> 1'b1;
`ifdef MULTICYCLE_ALU_MUL_EN
            // Low word doubles as the multiplier; product bits shift in from the top.
            DP_MUL: {hi_nxt, lo_nxt} = {sum_s, lo_r[WIDTH-1:1]};
`endif
            default: lo_nxt = lo_r;
        endcase
    end

    // Operand load and per-cycle stepping of the datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r  <= DP_SLL;
            cnt_r   <= {CW{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
`ifdef MULTICYCLE_ALU_MUL_EN
            hi_r    <= {WIDTH{1'b0}};
            mcand_r <= {WIDTH{1'b0}};
`endif
        end else if (load) begin
            mode_r  <= mode;
            cnt_r   <= (mode == DP_MUL) ? CW'(WIDTH) : {1'b0, k};
            lo_r    <= (mode == DP_MUL) ? b : a;
`ifdef MULTICYCLE_ALU_MUL_EN
            hi_r    <= {WIDTH{1'b0}};
            mcand_r <= a;
`endif
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r   <= cnt_r - CW'(1);
            lo_r    <= lo_nxt;
`ifdef MULTICYCLE_ALU_MUL_EN
            hi_r    <= hi_nxt;
`endif
        end else begin
            cnt_r   <= cnt_r;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// ----------------------------------------------------------------------------
// multicycle_alu
// Small ALU with single-cycle FWD/ADD/AND/OR/SUB, iterative SLL/SRL (one bit
// per cycle) and an optional iterative unsigned multiplier.
// Build option: define MULTICYCLE_ALU_MUL_EN to include the multiplier;
// otherwise opcode 111 completes in one cycle with ILLEGAL=1 and result 0.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   START, SELECT         request + opcode (sampled only while BUSY=0)
//   DATA1, DATA2          operand A, operand B / shift amount (low SHW bits)
//   BUSY                  multicycle operation in progress
//   DONE                  one-cycle pulse, results valid
//   RESULT, RESULT_HI     low word, high product word (0 unless MUL)
//   ZERO, CARRY, ILLEGAL  flags, updated together with DONE
// ----------------------------------------------------------------------------
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             ZERO,
    output logic             CARRY,
    output logic             ILLEGAL
);

    state_e           state_r, state_nxt_s;
    logic             accept_s, go_shift_s, go_mul_s, pend_set_s;
    logic             pend_r, busy_r, done_r, zero_r, carry_r, illegal_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, result_r, result_hi_r;
    logic [WIDTH-1:0] sc_res_s, dp_lo_s, dp_hi_s;
    logic             sc_carry_s, sc_illegal_s, dp_last_s;
    dp_mode_e         dp_mode_s;

    assign accept_s   = START && (state_r == IDLE);
    assign go_shift_s = accept_s && is_shift_op(SELECT) && (DATA2[SHW-1:0] != {SHW{1'b0}});
`ifdef MULTICYCLE_ALU_MUL_EN
    assign go_mul_s   = accept_s && (SELECT == OP_MUL);
`else
    assign go_mul_s   = 1'b0;
`endif
    // Everything else that is accepted finishes on the following edge.
    assign pend_set_s = accept_s && !go_shift_s && !go_mul_s;

    // Datapath mode for a newly launched multicycle operation.
    always_comb begin
        if (go_mul_s) begin
            dp_mode_s = DP_MUL;
        end else if (SELECT == OP_SLL) begin
            dp_mode_s = DP_SLL;
        end else begin
            dp_mode_s = DP_SRL;
        end
    end

    alu_shift_mul #(.WIDTH(WIDTH), .SHW(SHW)) u_shift_mul (
        .clk    (CLK),
        .reset  (RESET),
        .load   (go_shift_s || go_mul_s),
        .mode   (dp_mode_s),
        .a      (DATA1),
        .b      (DATA2),
        .k      (DATA2[SHW-1:0]),
        .last   (dp_last_s),
        .lo_nxt (dp_lo_s),
        .hi_nxt (dp_hi_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_shift_s) begin
                    state_nxt_s = SHIFT;
                end else if (go_mul_s) begin
                    state_nxt_s = MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT, MUL: begin
                if (dp_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture for operations that complete on the next edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_r <= 1'b0;
            op_r   <= OP_FWD;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
        end else begin
            pend_r <= pend_set_s;
            if (accept_s) begin
                op_r <= SELECT;
                a_r  <= DATA1;
                b_r  <= DATA2;
            end else begin
                op_r <= op_r;
            end
        end
    end

    // Single-cycle result from the captured operands.
    always_comb begin
        sc_res_s     = {WIDTH{1'b0}};
        sc_carry_s   = 1'b0;
        sc_illegal_s = 1'b0;
        case (op_r)
            OP_FWD: sc_res_s = b_r;
            OP_ADD: {sc_carry_s, sc_res_s} = {1'b0, a_r} + {1'b0, b_r};
            OP_AND: sc_res_s = a_r & b_r;
            OP_OR:  sc_res_s = a_r | b_r;
            OP_SUB: begin
                sc_res_s   = a_r - b_r;
                sc_carry_s = (a_r < b_r);
            end
            // Only reached with a zero shift count.
            OP_SLL, OP_SRL: sc_res_s = a_r;
`ifdef MULTICYCLE_ALU_MUL_EN
            OP_MUL: sc_illegal_s = 1'b0;
`else
            OP_MUL: sc_illegal_s = 1'b1;
`endif
            default: sc_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Registered outputs: results and flags change only together with DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            carry_r     <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            if (pend_r) begin
                done_r      <= 1'b1;
                result_r    <= sc_res_s;
                result_hi_r <= {WIDTH{1'b0}};
                zero_r      <= (sc_res_s == {WIDTH{1'b0}});
                carry_r     <= sc_carry_s;
                illegal_r   <= sc_illegal_s;
            end else if (dp_last_s && (state_r != IDLE)) begin
                done_r      <= 1'b1;
                result_r    <= dp_lo_s;
                result_hi_r <= dp_hi_s;
                zero_r      <= ({dp_hi_s, dp_lo_s} == {(2*WIDTH){1'b0}});
                carry_r     <= 1'b0;
                illegal_r   <= 1'b0;
            end else begin
                done_r      <= 1'b0;
            end
        end
    end

    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign RESULT    = result_r;
    assign RESULT_HI = result_hi_r;
    assign ZERO      = zero_r;
    assign CARRY     = carry_r;
    assign ILLEGAL   = illegal_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// ----------------------------------------------------------------------------
// tb_multicycle_alu
// Self-checking bench for multicycle_alu (WIDTH=8): directed vector table,
// corner sequences (dropped START, reset abort, back-to-back) and random
// operations against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_multicycle_alu;

    logic       CLK = 1'b0;
    logic       RESET, START;
    logic [2:0] SELECT;
    logic [7:0] DATA1, DATA2;
    logic       BUSY, DONE, ZERO, CARRY, ILLEGAL;
    logic [7:0] RESULT, RESULT_HI;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       zero;
        logic       carry;
        logic       illegal;
        logic       busy;
        int         lat;
    } vec_t;

    multicycle_alu #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .ILLEGAL   (ILLEGAL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode meaning.
    function automatic vec_t model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        vec_t v;
        int ia = int'(a);
        int ib = int'(b);
        int k  = ib % 8;
        int r  = 0;
        int h  = 0;
        int p;
        v.sel = sel; v.a = a; v.b = b;
        v.carry = 1'b0; v.illegal = 1'b0; v.busy = 1'b0; v.lat = 1;
        case (sel)
            3'd0: r = ib;
            3'd1: begin r = (ia + ib) % 256; v.carry = (ia + ib) > 255; end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: begin r = (ia - ib + 256) % 256; v.carry = (ia < ib); end
            3'd5: begin r = (ia * (1 << k)) % 256; if (k > 0) begin v.busy = 1'b1; v.lat = k; end end
            3'd6: begin r = ia / (1 << k); if (k > 0) begin v.busy = 1'b1; v.lat = k; end end
            default: begin
`ifdef MULTICYCLE_ALU_MUL_EN
                p = ia * ib; r = p % 256; h = p / 256; v.busy = 1'b1; v.lat = 8;
`else
                p = 0; v.illegal = 1'b1;
`endif
            end
        endcase
        v.res  = r[7:0];
        v.hi   = h[7:0];
        v.zero = (r == 0) && (h == 0);
        return v;
    endfunction

    // Issue one operation and check latency, BUSY after capture, and outputs.
    task automatic run_op(input vec_t v, input string nm);
        int  lat = 0;
        bit  got = 0;
        logic busy_seen;
        @(negedge CLK);
        START = 1'b1; SELECT = v.sel; DATA1 = v.a; DATA2 = v.b;
        @(posedge CLK); #1;
        busy_seen = BUSY;
        @(negedge CLK);
        START = 1'b0;
        while (!got && lat < 100) begin
            @(posedge CLK); #1;
            lat++;
            if (DONE) got = 1;
        end
        chk({nm, "_busy"}, busy_seen, v.busy);
        if (!got) begin
            chk({nm, "_timeout"}, 1'b0, 1'b1);
        end else begin
            chk({nm, "_lat"},     lat,       v.lat);
            chk({nm, "_res"},     RESULT,    v.res);
            chk({nm, "_hi"},      RESULT_HI, v.hi);
            chk({nm, "_zero"},    ZERO,      v.zero);
            chk({nm, "_carry"},   CARRY,     v.carry);
            chk({nm, "_illegal"}, ILLEGAL,   v.illegal);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_busy"},    BUSY,      1'b0);
        chk({nm, "_done"},    DONE,      1'b0);
        chk({nm, "_res"},     RESULT,    8'h00);
        chk({nm, "_hi"},      RESULT_HI, 8'h00);
        chk({nm, "_zero"},    ZERO,      1'b1);
        chk({nm, "_carry"},   CARRY,     1'b0);
        chk({nm, "_illegal"}, ILLEGAL,   1'b0);
    endtask

    vec_t tbl[13];
    vec_t b2b[4];

    initial begin
        int   dcnt, first;
        logic [7:0] rsav;

        // sel, a, b, res, hi, zero, carry, illegal, busy, lat
        tbl[0]  = '{3'd1, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1]  = '{3'd4, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{3'd4, 8'h03, 8'h04, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[3]  = '{3'd5, 8'h81, 8'h03, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3};
        tbl[4]  = '{3'd0, 8'h12, 8'h34, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{3'd6, 8'h80, 8'h07, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 7};
        tbl[8]  = '{3'd5, 8'h5A, 8'h08, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{3'd6, 8'h01, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1};
`ifdef MULTICYCLE_ALU_MUL_EN
        tbl[11] = '{3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 8};
        tbl[12] = '{3'd7, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8};
`else
        tbl[11] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tbl[12] = '{3'd7, 8'h00, 8'h37, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
`endif

        RESET = 1'b1; START = 1'b0; SELECT = 3'd0; DATA1 = 8'h00; DATA2 = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_state("reset");
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // SLL 0x81 by 3 with a second START while busy: must be dropped.
        @(negedge CLK);
        START = 1'b1; SELECT = 3'd5; DATA1 = 8'h81; DATA2 = 8'h03;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b1; SELECT = 3'd1; DATA1 = 8'h01; DATA2 = 8'h01;
        dcnt = 0; first = 0; rsav = 8'h00;
        for (int c = 1; c <= 12; c++) begin
            @(posedge CLK); #1;
            if (c == 1) START = 1'b0;
            if (DONE) begin
                dcnt++;
                if (first == 0) begin first = c; rsav = RESULT; end
            end
        end
        chk("drop_done_count", dcnt, 1);
        chk("drop_done_edge", first, 3);
        chk("drop_res", rsav, 8'h08);

        // MUL 13*11 aborted by reset at N+4, with a simultaneous START.
        @(negedge CLK);
        START = 1'b1; SELECT = 3'd7; DATA1 = 8'd13; DATA2 = 8'd11;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1; START = 1'b1; SELECT = 3'd1; DATA1 = 8'h01; DATA2 = 8'h01;
        @(posedge CLK); #1;
        chk_reset_state("abort");
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_busy", BUSY, 1'b0);
        run_op(model(3'd1, 8'h01, 8'h01), "post_abort_add");

        // Back-to-back single-cycle ops with START held high.
        b2b[0] = model(3'd1, 8'h7F, 8'h01);
        b2b[1] = model(3'd4, 8'h10, 8'h20);
        b2b[2] = model(3'd2, 8'hAA, 8'h0F);
        b2b[3] = model(3'd0, 8'h00, 8'h99);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i >= 2) begin
                chk($sformatf("b2b%0d_done", i - 2), DONE, 1'b1);
                chk($sformatf("b2b%0d_res", i - 2), RESULT, b2b[i-2].res);
                chk($sformatf("b2b%0d_carry", i - 2), CARRY, b2b[i-2].carry);
            end
            if (i < 4) begin
                START = 1'b1; SELECT = b2b[i].sel; DATA1 = b2b[i].a; DATA2 = b2b[i].b;
            end else begin
                START = 1'b0;
            end
        end
        @(negedge CLK);
        chk("b2b_done_drop", DONE, 1'b0);

        // Random operations, each started on the DONE cycle of the previous one.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] s;
            logic [7:0] x, y;
            s = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = 8'($urandom);
            run_op(model(s, x, y), $sformatf("rnd%0d_op%0d", i, s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
